branch_resolve: RTL and testbench
=================================

# branch_resolve

Pipelined, parametrised branch-resolution stage for the WISC datapath. Accepts a compare operand pair, a 3-bit condition code and the fetch-time prediction, computes ALU-style flags at WIDTH bits, and registers the outcome (taken, mispredict, redirect PC) behind a valid/ready handshake. Sits between decode/execute and the PC-select logic. An optional 2-bit-counter branch history table supplies predictions to fetch.

## Interface
- WIDTH, 16: operand width in bits (≥2)
- PC_W, 16: PC width
- BHT_DEPTH, 16: history-table entries, power of two (used only with BRANCH_RESOLVE_BHT_EN)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  request present
- in_ready  out  1  stage can accept
- cond  in  3  condition code (package encoding)
- op_a, op_b  in  WIDTH  compare operands; flags come from op_a − op_b
- pc  in  PC_W  address of the branch
- target  in  PC_W  taken target
- in_pred  in  1  prediction fetch used for this branch
- flush  in  1  discard held result and this cycle's request
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- taken  out  1  condition met
- mispredict  out  1  taken ≠ in_pred
- redirect_pc  out  PC_W  correct next PC
- flags_q  out  4  {sf, zf, of, cf} of the last accepted request
- lookup_pc  in  PC_W  fetch PC for prediction
- lookup_taken  out  1  prediction for lookup_pc (combinational)

## Operation
- Flags, WIDTH-bit subtract: d = op_a − op_b; zf = (d==0); sf = d[MSB]; of = signed overflow of the subtract; cf = borrow-free carry out of op_a + ~op_b + 1.
- Conditions: 000 never; 001 CARRY (cf); 010 EQ (zf); 011 GE signed (sf==of); 100 LT signed (sf≠of); 101 NE (!zf); 110 LE signed (zf | sf≠of); 111 always.
- Accept when in_valid & in_ready & !flush. On accept: register taken, mispredict = taken ^ in_pred, redirect_pc = taken ? target : pc+2 (mod 2^PC_W), flags_q.
- in_ready = !out_valid | out_ready (single-entry output register, full throughput).
- Held result stays stable while out_valid & !out_ready.
- flush: out_valid ← 0 next edge; request presented in the same cycle is dropped (no flags_q or BHT update). Flush beats simultaneous accept.

## Timing
- Latency 1: accept at edge N → out_valid, taken, mispredict, redirect_pc at N+1.
- Back-to-back: new accept while out_ready=1 replaces the result same edge; no bubble.
- Reset values: out_valid 0, taken 0, mispredict 0, redirect_pc 0, flags_q 0, all BHT counters 2'b01; in_ready 1 out of reset.
- Reset asserted mid-operation clears held result immediately (asynchronous); no partial update.
- lookup_taken has zero latency; same-cycle lookup and update of one index return the pre-update counter.

## Configuration
- BRANCH_RESOLVE_BHT_EN defined: BHT_DEPTH 2-bit saturating counters indexed by pc[log2(BHT_DEPTH):1]; on each accept the entry for pc increments if taken (saturate 11), else decrements (saturate 00); lookup_taken = counter[1] at lookup_pc index.
- Undefined: no table; lookup_taken tied 0 (static not-taken); all other behaviour unchanged.

## Structure
- Package branch_pkg: cond encodings (COND_NEVER … COND_ALWAYS), flag bit indices, counter reset constant 2'b01.
- Sub-module branch_bht: counter array, lookup port, update port; instantiated only under the macro.

## Test plan
- WIDTH=16, op_a=0x8000, op_b=0x0001, cond LT → taken=1 (of=1, sf=0), redirect_pc=target, one cycle after accept.
- op_a=op_b=0x1234, cond NE, in_pred=1 → taken=0, mispredict=1, redirect_pc=pc+2; pc=0xFFFE wraps to 0x0000.
- out_ready held 0 for 3 cycles with in_valid=1 → in_ready=0, outputs stable, no second accept; release → next request accepted same edge.
- flush with in_valid=1 and out_valid=1 → out_valid=0 next cycle, flags_q unchanged.
- Macro on: four taken branches at pc=0x0010 → counter 01→10→11→11, lookup_taken=1 after first; two not-taken → 01, lookup_taken=0.
- rst_n pulsed low mid-stream → out_valid, flags_q, counters return to reset values without a clock edge.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared encodings for the WISC branch-resolution stage: condition codes,
// flag bit positions and the reset value of the prediction counters.
package branch_pkg;

    typedef enum logic [2:0] {
        COND_NEVER  = 3'b000,
        COND_CARRY  = 3'b001,
        COND_EQ     = 3'b010,
        COND_GE     = 3'b011,
        COND_LT     = 3'b100,
        COND_NE     = 3'b101,
        COND_LE     = 3'b110,
        COND_ALWAYS = 3'b111
    } cond_e;

    localparam int FLAG_CF = 0;
    localparam int FLAG_OF = 1;
    localparam int FLAG_ZF = 2;
    localparam int FLAG_SF = 3;

    localparam logic [1:0] CTR_RESET = 2'b01;

    // Signed "less than" is sf != of after the subtract op_a - op_b.
    function automatic logic cond_met(input logic [2:0] code, input logic [3:0] f);
        logic lt;
        lt = f[FLAG_SF] ^ f[FLAG_OF];
        case (cond_e'(code))
            COND_NEVER:  cond_met = 1'b0;
            COND_CARRY:  cond_met = f[FLAG_CF];
            COND_EQ:     cond_met = f[FLAG_ZF];
            COND_GE:     cond_met = !lt;
            COND_LT:     cond_met = lt;
            COND_NE:     cond_met = !f[FLAG_ZF];
            COND_LE:     cond_met = f[FLAG_ZF] | lt;
            COND_ALWAYS: cond_met = 1'b1;
            default:     cond_met = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: DEPTH two-bit saturating counters with one
// combinational lookup port and one update port (lookup sees pre-update value).
module branch_bht
    import branch_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] ctr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr[i] <= CTR_RESET;
            end
        end else if (upd_en) begin
            if (upd_taken) begin
                if (ctr[upd_idx] != 2'b11) ctr[upd_idx] <= ctr[upd_idx] + 2'd1;
            end else begin
                if (ctr[upd_idx] != 2'b00) ctr[upd_idx] <= ctr[upd_idx] - 2'd1;
            end
        end
    end

    assign lookup_taken = ctr[lookup_idx][1];

endmodule

// File: rtl/branch_resolve.sv
// Pipelined branch-resolution stage with a single-entry valid/ready output register.
// Define BRANCH_RESOLVE_BHT_EN to add a 2-bit-counter history table for fetch prediction.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int PC_W      = 16,
    parameter int BHT_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      cond,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] target,
    input  logic            in_pred,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic            mispredict,
    output logic [PC_W-1:0] redirect_pc,
    output logic [3:0]      flags_q,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            lookup_taken
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [3:0]       flags;
    logic             cond_taken;
    logic             accept;
    logic             unused_lookup;

    // Subtract as op_a + ~op_b + 1 so the carry out is the no-borrow flag.
    always_comb begin
        sum   = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
        diff  = sum[WIDTH-1:0];
        flags = '0;
        flags[FLAG_CF] = sum[WIDTH];
        flags[FLAG_ZF] = (diff == '0);
        flags[FLAG_SF] = diff[WIDTH-1];
        flags[FLAG_OF] = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
    end

    assign cond_taken = cond_met(cond, flags);
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready && !flush;

    // Flush wins over a same-cycle accept and leaves flags_q untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            taken       <= 1'b0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
            flags_q     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            taken       <= cond_taken;
            mispredict  <= cond_taken ^ in_pred;
            redirect_pc <= cond_taken ? target : pc + PC_W'(2);
            flags_q     <= flags;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign unused_lookup = ^lookup_pc;

`ifdef BRANCH_RESOLVE_BHT_EN
    localparam int IDX_W = $clog2(BHT_DEPTH);

    branch_bht #(
        .DEPTH(BHT_DEPTH)
    ) u_bht (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_idx   (lookup_pc[IDX_W:1]),
        .lookup_taken (lookup_taken),
        .upd_en       (accept),
        .upd_idx      (pc[IDX_W:1]),
        .upd_taken    (cond_taken)
    );
`else
    localparam int unused_depth = BHT_DEPTH;

    assign lookup_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: scoreboard of expected results,
// independent flag/condition/BHT model, backpressure, flush and async reset.
module tb_branch_resolve;
    import branch_pkg::*;

    localparam int WIDTH = 16;
    localparam int PC_W  = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      cond;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] target;
    logic            in_pred;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic            taken;
    logic            mispredict;
    logic [PC_W-1:0] redirect_pc;
    logic [3:0]      flags_q;
    logic [PC_W-1:0] lookup_pc;
    logic            lookup_taken;

    branch_resolve #(
        .WIDTH(WIDTH), .PC_W(PC_W), .BHT_DEPTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .cond(cond), .op_a(op_a), .op_b(op_b), .pc(pc), .target(target),
        .in_pred(in_pred), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .taken(taken), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .flags_q(flags_q), .lookup_pc(lookup_pc), .lookup_taken(lookup_taken)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            tk;
        logic            mp;
        logic [PC_W-1:0] rpc;
    } exp_t;

    exp_t       sb[$];
    exp_t       lastExp;
    logic       mv;
    logic [3:0] flagsModel;
    logic [1:0] ctrModel [16];
    int         errors = 0;
    int         checks = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] modelFlags(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] d;
        int          sd;
        logic [3:0]  f;
        d  = a - b;
        sd = int'($signed(a)) - int'($signed(b));
        f  = '0;
        f[3] = d[15];
        f[2] = (a == b);
        f[1] = (sd > 32767) || (sd < -32768);
        f[0] = (a >= b);
        return f;
    endfunction

    function automatic logic modelTaken(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
        case (c)
            3'd0:    return 1'b0;
            3'd1:    return a >= b;
            3'd2:    return a == b;
            3'd3:    return $signed(a) >= $signed(b);
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return a != b;
            3'd6:    return $signed(a) <= $signed(b);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic modelPred(input logic [15:0] lpc);
`ifdef BRANCH_RESOLVE_BHT_EN
        return ctrModel[lpc[4:1]][1];
`else
        return 1'b0;
`endif
    endfunction

    task automatic resetModel();
        mv         = 1'b0;
        flagsModel = '0;
        lastExp    = '0;
        sb.delete();
        for (int i = 0; i < 16; i++) ctrModel[i] = 2'b01;
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] c, input logic [15:0] a,
                                 input logic [15:0] b, input logic [15:0] p, input logic [15:0] t,
                                 input logic pr, input logic fl, input logic ordy,
                                 input logic [15:0] lpc);
        logic acc;
        logic tk;
        exp_t e;
        @(negedge clk);
        in_valid = v; cond = c; op_a = a; op_b = b; pc = p; target = t;
        in_pred = pr; flush = fl; out_ready = ordy; lookup_pc = lpc;
        #1;
        checkOutput("in_ready", 32'(in_ready), 32'(!mv || ordy));
        checkOutput("lookup_taken", 32'(lookup_taken), 32'(modelPred(lpc)));
        acc = v && (!mv || ordy) && !fl;
        if (acc) begin
            tk = modelTaken(c, a, b);
            sb.push_back('{tk: tk, mp: tk ^ pr, rpc: tk ? t : p + 16'd2});
            flagsModel = modelFlags(a, b);
            if (tk) begin
                if (ctrModel[p[4:1]] != 2'b11) ctrModel[p[4:1]] = ctrModel[p[4:1]] + 2'd1;
            end else begin
                if (ctrModel[p[4:1]] != 2'b00) ctrModel[p[4:1]] = ctrModel[p[4:1]] - 2'd1;
            end
        end
        @(posedge clk);
        #1;
        if (fl) mv = 1'b0;
        else if (acc) mv = 1'b1;
        else if (ordy) mv = 1'b0;
        checkOutput("out_valid", 32'(out_valid), 32'(mv));
        checkOutput("flags_q", 32'(flags_q), 32'(flagsModel));
        if (acc) begin
            e = sb.pop_front();
            lastExp = e;
        end
        if (mv) begin
            checkOutput("taken", 32'(taken), 32'(lastExp.tk));
            checkOutput("mispredict", 32'(mispredict), 32'(lastExp.mp));
            checkOutput("redirect_pc", 32'(redirect_pc), 32'(lastExp.rpc));
        end
    endtask

    logic [15:0] tabA [6];
    logic [15:0] tabB [6];

    initial begin
        tabA = '{16'h8000, 16'h1234, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h0005};
        tabB = '{16'h0001, 16'h1234, 16'h8000, 16'hFFFF, 16'hFFFF, 16'h0003};
        rst_n = 1'b0; in_valid = 0; cond = 0; op_a = 0; op_b = 0; pc = 0; target = 0;
        in_pred = 0; flush = 0; out_ready = 1; lookup_pc = 16'h0010;
        resetModel();
        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_taken", 32'(taken), 32'd0);
        checkOutput("rst_mispredict", 32'(mispredict), 32'd0);
        checkOutput("rst_redirect_pc", 32'(redirect_pc), 32'd0);
        checkOutput("rst_flags_q", 32'(flags_q), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_lookup", 32'(lookup_taken), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // LT with signed overflow, then NE mispredict with PC wrap
        applyStimulus(1, COND_LT, 16'h8000, 16'h0001, 16'h0100, 16'h0200, 0, 0, 1, 16'h0100);
        checkOutput("lt_taken_direct", 32'(taken), 32'd1);
        checkOutput("lt_flags_direct", 32'(flags_q), 32'b0011);
        applyStimulus(1, COND_NE, 16'h1234, 16'h1234, 16'hFFFE, 16'h0300, 1, 0, 1, 16'h0100);
        checkOutput("wrap_redirect_direct", 32'(redirect_pc), 32'h0000);
        checkOutput("ne_mispredict_direct", 32'(mispredict), 32'd1);

        // Backpressure: three stalled cycles, then release accepts on the same edge
        applyStimulus(1, COND_EQ, 16'h0007, 16'h0007, 16'h0020, 16'h0080, 0, 0, 0, 16'h0020);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, COND_ALWAYS, 16'(i), 16'h0001, 16'h0030, 16'h00A0, 0, 0, 0, 16'h0030);
        applyStimulus(1, COND_GE, 16'h0001, 16'hFFFF, 16'h0040, 16'h00C0, 1, 0, 1, 16'h0040);

        // Flush with a held result and a new request pending
        applyStimulus(1, COND_EQ, 16'h0001, 16'h0002, 16'h0050, 16'h00D0, 0, 0, 0, 16'h0050);
        applyStimulus(1, COND_ALWAYS, 16'h7777, 16'h0000, 16'h0052, 16'h00E0, 0, 1, 0, 16'h0052);
        applyStimulus(0, COND_NEVER, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 1, 16'h0052);

        // Every condition against boundary operand pairs, back-to-back
        for (int c = 0; c < 8; c++)
            for (int i = 0; i < 6; i++)
                applyStimulus(1, 3'(c), tabA[i], tabB[i], 16'(16'h0060 + 2 * i),
                              16'(16'h1000 + c), 1'(c), 0, 1, 16'(16'h0060 + 2 * i));

        // History counter at pc 0x0010: four taken, two not-taken
        for (int i = 0; i < 4; i++)
            applyStimulus(1, COND_ALWAYS, 16'h0, 16'h0, 16'h0010, 16'h0400, 0, 0, 1, 16'h0010);
        applyStimulus(0, COND_NEVER, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 1, 16'h0010);
`ifdef BRANCH_RESOLVE_BHT_EN
        checkOutput("bht_saturated", 32'(lookup_taken), 32'd1);
`else
        checkOutput("static_not_taken", 32'(lookup_taken), 32'd0);
`endif
        for (int i = 0; i < 2; i++)
            applyStimulus(1, COND_NEVER, 16'h0, 16'h0, 16'h0010, 16'h0400, 1, 0, 1, 16'h0010);
        applyStimulus(0, COND_NEVER, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 1, 16'h0010);
        checkOutput("bht_after_not_taken", 32'(lookup_taken), 32'd0);

        // Drive the counter high again, then reset asynchronously mid-stream
        for (int i = 0; i < 3; i++)
            applyStimulus(1, COND_ALWAYS, 16'h5, 16'h3, 16'h0010, 16'h0500, 0, 0, 1, 16'h0010);
        @(negedge clk);
        in_valid = 1; cond = COND_ALWAYS; lookup_pc = 16'h0010;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_flags_q", 32'(flags_q), 32'd0);
        checkOutput("async_redirect", 32'(redirect_pc), 32'd0);
        checkOutput("async_lookup", 32'(lookup_taken), 32'd0);
        resetModel();
        in_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic with occasional flush and backpressure
        for (int i = 0; i < 40; i++)
            applyStimulus(1'($urandom_range(0, 3) != 0), 3'($urandom), 16'($urandom), 16'($urandom),
                          16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0),
                          1'($urandom_range(0, 2) != 0), 16'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
